// File: rtl/count_sequencer.sv
// Bounded, restartable up-counter: runs num_loops passes of 0..term_cnt after a start pulse,
// with hold/abort control and registered q, loop_idx, busy, wrap and done outputs.
module count_sequencer #(
    parameter int WIDTH  = 3,
    parameter int LOOP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              hold,
    input  logic [WIDTH-1:0]  term_cnt,
    input  logic [LOOP_W-1:0] num_loops,
    output logic [WIDTH-1:0]  q,
    output logic [LOOP_W-1:0] loop_idx,
    output logic              busy,
    output logic              wrap,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  term_r;
    logic [LOOP_W-1:0] loops_r;
    logic              at_term;
    logic              last_pass;

    // Wrap is decided by comparison against the latched terminal, never by overflow.
    assign at_term   = (q == term_r);
    assign last_pass = (loop_idx == loops_r - LOOP_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            q        <= '0;
            loop_idx <= '0;
            busy     <= 1'b0;
            wrap     <= 1'b0;
            done     <= 1'b0;
            term_r   <= '0;
            loops_r  <= '0;
        end else begin
            wrap <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        term_r   <= term_cnt;
                        loops_r  <= num_loops;
                        q        <= '0;
                        loop_idx <= '0;
                        busy     <= 1'b1;
                        if (num_loops == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state    <= IDLE;
                        q        <= '0;
                        loop_idx <= '0;
                        busy     <= 1'b0;
                    end else if (!hold) begin
                        if (!at_term) begin
                            q <= q + WIDTH'(1);
                        end else begin
                            q    <= '0;
                            wrap <= 1'b1;
                            if (last_pass) begin
                                loop_idx <= '0;
                                done     <= 1'b1;
                                state    <= DONE;
                            end else begin
                                loop_idx <= loop_idx + LOOP_W'(1);
                            end
                        end
                    end
                end
                DONE: begin
                    // Single-cycle state; abort and start both land in IDLE here.
                    state    <= IDLE;
                    busy     <= 1'b0;
                    q        <= '0;
                    loop_idx <= '0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer: directed scenarios plus random traffic, each cycle compared
// against a model that tracks progress as a plain step count divided into passes.
module tb_count_sequencer;

    localparam int WIDTH  = 3;
    localparam int LOOP_W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              hold = 1'b0;
    logic [WIDTH-1:0]  term_cnt = '0;
    logic [LOOP_W-1:0] num_loops = '0;
    logic [WIDTH-1:0]  q;
    logic [LOOP_W-1:0] loop_idx;
    logic              busy;
    logic              wrap;
    logic              done;

    int checks = 0;
    int errors = 0;

    // Model: phase 0 idle, 1 counting, 2 done cycle; m_steps = unstalled edges taken so far.
    int m_phase = 0;
    int m_steps = 0;
    int m_T = 0;
    int m_L = 0;
    bit m_wrap = 1'b0;
    bit m_done = 1'b0;

    logic [9:0] obs;
    assign obs = {q, loop_idx, busy, wrap, done};

    count_sequencer #(.WIDTH(WIDTH), .LOOP_W(LOOP_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .hold(hold),
        .term_cnt(term_cnt), .num_loops(num_loops),
        .q(q), .loop_idx(loop_idx), .busy(busy), .wrap(wrap), .done(done)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        m_phase = 0; m_steps = 0; m_T = 0; m_L = 0; m_wrap = 0; m_done = 0;
    endfunction

    function automatic void model_step();
        m_wrap = 0;
        m_done = 0;
        case (m_phase)
            0: if (start) begin
                m_T = int'(term_cnt);
                m_L = int'(num_loops);
                m_steps = 0;
                if (m_L == 0) begin
                    m_phase = 2;
                    m_done = 1;
                end else begin
                    m_phase = 1;
                end
            end
            1: if (abort) begin
                m_phase = 0;
                m_steps = 0;
            end else if (!hold) begin
                m_steps++;
                if (m_steps % (m_T + 1) == 0) m_wrap = 1;
                if (m_steps == m_L * (m_T + 1)) begin
                    m_phase = 2;
                    m_done = 1;
                    m_steps = 0;
                end
            end
            default: m_phase = 0;
        endcase
    endfunction

    function automatic logic [9:0] exp_vec();
        int q_e;
        int i_e;
        q_e = (m_phase == 1) ? m_steps % (m_T + 1) : 0;
        i_e = (m_phase == 1) ? m_steps / (m_T + 1) : 0;
        return {3'(q_e), 4'(i_e), (m_phase != 0), m_wrap, m_done};
    endfunction

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        checks++;
        if (obs !== 10'b0) begin
            errors++; $display("FAIL reset_assert got %b want %b", obs, 10'b0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        for (int e = 0; e < 3; e++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL reset_idle e=%0d got %b want %b", e, obs, exp_vec());
            end
        end
        term_cnt = 3'd5; num_loops = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 2; e++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL reset_prerun e=%0d got %b want %b", e, obs, exp_vec());
            end
        end
        // Async assert away from any edge: outputs must clear before the next rising edge.
        #1 rst = 1'b0;
        #1;
        checks++;
        if (q !== 3'd0 || busy !== 1'b0 || done !== 1'b0 || loop_idx !== 4'd0) begin
            errors++; $display("FAIL reset_midrun got q=%0d busy=%b done=%b want q=0 busy=0 done=0", q, busy, done);
        end
        model_reset();
        #2 rst = 1'b1;
        for (int e = 0; e < 3; e++) begin
            tick();
            checks++;
            if (obs !== exp_vec() || busy !== 1'b0) begin
                errors++; $display("FAIL reset_release e=%0d got %b want %b", e, obs, exp_vec());
            end
        end
        $display("reset: asserted mid-run at q=2, idle after release");
    endtask

    task automatic test_basic();
        int qs[9]  = '{1, 2, 3, 0, 1, 2, 3, 0, 0};
        int ids[9] = '{0, 0, 0, 1, 1, 1, 1, 0, 0};
        term_cnt = 3'd3; num_loops = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (obs !== exp_vec() || busy !== 1'b1) begin
            errors++; $display("FAIL basic_e0 got %b want %b", obs, exp_vec());
        end
        for (int e = 1; e <= 9; e++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL basic_model e=%0d got %b want %b", e, obs, exp_vec());
            end
            checks++;
            if (q !== 3'(qs[e-1]) || loop_idx !== 4'(ids[e-1]) || wrap !== (e == 4 || e == 8)
                || done !== (e == 8) || busy !== (e <= 8)) begin
                errors++; $display("FAIL basic_plan e=%0d got q=%0d idx=%0d wrap=%b done=%b busy=%b want q=%0d idx=%0d",
                                   e, q, loop_idx, wrap, done, busy, qs[e-1], ids[e-1]);
            end
        end
        $display("basic: term=3 loops=2 run complete");
    endtask

    task automatic test_hold();
        int done_edge = -1;
        term_cnt = 3'd3; num_loops = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            if (e == 3) hold = 1'b1;
            if (e == 6) hold = 1'b0;
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL hold_model e=%0d got %b want %b", e, obs, exp_vec());
            end
            if (e >= 3 && e <= 5) begin
                checks++;
                if (q !== 3'd2) begin
                    errors++; $display("FAIL hold_frozen e=%0d got q=%0d want q=2", e, q);
                end
            end
            if (done === 1'b1 && done_edge < 0) done_edge = e;
            if (busy !== 1'b1) break;
        end
        hold = 1'b0;
        checks++;
        if (done_edge !== 11) begin
            errors++; $display("FAIL hold_latency got done_edge=%0d want 11", done_edge);
        end
        $display("hold: 3 stalled cycles, done at edge %0d", done_edge);
    endtask

    task automatic test_abort();
        int dones = 0;
        term_cnt = 3'd3; num_loops = 4'd2; start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        checks++;
        if (q !== 3'd1 || loop_idx !== 4'd1) begin
            errors++; $display("FAIL abort_pre got q=%0d idx=%0d want q=1 idx=1", q, loop_idx);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (obs !== exp_vec() || obs !== 10'b0) begin
            errors++; $display("FAIL abort_exit got %b want %b", obs, 10'b0);
        end
        for (int e = 0; e < 3; e++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_nodone got dones=%0d busy=%b want dones=0 busy=0", dones, busy);
        end
        term_cnt = 3'd1; num_loops = 4'd3; start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL abort_restart e=%0d got %b want %b", e, obs, exp_vec());
            end
            if (done === 1'b1) dones++;
            if (busy !== 1'b1) break;
        end
        checks++;
        if (dones !== 1) begin
            errors++; $display("FAIL abort_restart_done got dones=%0d want 1", dones);
        end
        $display("abort: pass 1 q=1 aborted, restart completed");
    endtask

    task automatic test_corners();
        int terms[3] = '{0, 0, 7};
        int loops[3] = '{3, 0, 1};
        int dedge[3] = '{3, 0, 8};
        for (int k = 0; k < 3; k++) begin
            int done_edge = -1;
            int wraps = 0;
            term_cnt = 3'(terms[k]); num_loops = 4'(loops[k]); start = 1'b1;
            tick();
            start = 1'b0;
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL corner%0d_e0 got %b want %b", k, obs, exp_vec());
            end
            if (done === 1'b1) done_edge = 0;
            for (int e = 1; e <= 40; e++) begin
                if (busy !== 1'b1) break;
                tick();
                checks++;
                if (obs !== exp_vec()) begin
                    errors++; $display("FAIL corner%0d_model e=%0d got %b want %b", k, e, obs, exp_vec());
                end
                if (wrap === 1'b1) wraps++;
                if (done === 1'b1 && done_edge < 0) done_edge = e;
            end
            checks++;
            if (done_edge !== dedge[k] || wraps !== loops[k] || busy !== 1'b0) begin
                errors++; $display("FAIL corner%0d_timing got done_edge=%0d wraps=%0d want done_edge=%0d wraps=%0d",
                                   k, done_edge, wraps, dedge[k], loops[k]);
            end
            $display("corner: term=%0d loops=%0d done at edge %0d", terms[k], loops[k], done_edge);
        end
    endtask

    task automatic test_ignored();
        int done_edge = -1;
        term_cnt = 3'd2; num_loops = 4'd2; start = 1'b1;
        tick();
        for (int e = 1; e <= 20; e++) begin
            start = 1'b0;
            if (e == 2) begin
                start = 1'b1; term_cnt = 3'd5; num_loops = 4'd7;
            end
            if (done === 1'b1) start = 1'b1;
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL ignored_model e=%0d got %b want %b", e, obs, exp_vec());
            end
            if (done === 1'b1 && done_edge < 0) done_edge = e;
            if (done_edge > 0 && e > done_edge) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++; $display("FAIL ignored_norestart e=%0d got busy=%b want 0", e, busy);
                end
            end
            if (done_edge > 0 && e >= done_edge + 2) break;
        end
        start = 1'b0;
        checks++;
        if (done_edge !== 6) begin
            errors++; $display("FAIL ignored_timing got done_edge=%0d want 6", done_edge);
        end
        $display("ignored: restarts and input changes during run, done at edge %0d", done_edge);
    endtask

    task automatic test_back_to_back();
        int runs = 0;
        int second_done = -1;
        bit restarted = 1'b0;
        term_cnt = 3'd1; num_loops = 4'd1; start = 1'b1;
        for (int e = 0; e <= 30; e++) begin
            tick();
            start = 1'b0;
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL b2b_model e=%0d got %b want %b", e, obs, exp_vec());
            end
            if (done === 1'b1) begin
                runs++;
                if (runs == 2) second_done = e;
            end
            if (busy === 1'b0 && runs == 1 && !restarted) begin
                start = 1'b1;
                restarted = 1'b1;
            end
            if (busy === 1'b0 && runs == 2) break;
        end
        checks++;
        if (runs !== 2 || second_done !== 6) begin
            errors++; $display("FAIL b2b_timing got runs=%0d second_done=%0d want runs=2 second_done=6", runs, second_done);
        end
        $display("back_to_back: second run done at edge %0d", second_done);
    endtask

    task automatic test_random();
        int runs = 0;
        for (int e = 0; e < 800; e++) begin
            start     = ($urandom_range(0, 3) == 0);
            abort     = ($urandom_range(0, 23) == 0);
            hold      = ($urandom_range(0, 4) == 0);
            term_cnt  = 3'($urandom_range(0, 7));
            num_loops = 4'($urandom_range(0, 4));
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL random e=%0d got %b want %b", e, obs, exp_vec());
            end
            if (done === 1'b1) begin
                runs++;
                $display("random: run %0d done at cycle %0d term=%0d loops=%0d", runs, e, m_T, m_L);
            end
        end
        start = 1'b0; abort = 1'b0; hold = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_hold();
        test_abort();
        test_corners();
        test_ignored();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

endmodule

// File: doc/count_sequencer.md
# count_sequencer

Controller that sequences a WIDTH-bit up-counter through a programmed number of count passes. Each pass runs from 0 to a terminal value and wraps. Software or an upstream FSM starts a run with a one-cycle start pulse and can stall it with hold or kill it with abort. The block reports the live count, pass index, per-pass wrap strobes and a completion strobe. It sits between the control logic and counter-based timing datapaths, replacing free-running counters where a bounded, restartable count is required.

## Interface
- WIDTH, 3, counter width; count range 0..2^WIDTH-1
- LOOP_W, 4, width of the pass-count field
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset; asserting low immediately forces reset state, release is synchronous to clk
- start  in  1  one-cycle request to begin a run; sampled only in IDLE
- abort  in  1  terminates a run; highest priority in RUN/DONE
- hold  in  1  stalls counting while high (RUN only)
- term_cnt  in  WIDTH  terminal count per pass; latched on accepted start
- num_loops  in  LOOP_W  number of passes; latched on accepted start
- q  out  WIDTH  current count
- loop_idx  out  LOOP_W  index of current pass, 0-based
- busy  out  1  high whenever state != IDLE
- wrap  out  1  one-cycle strobe: q wrapped term→0 on the preceding edge
- done  out  1  one-cycle strobe: run completed normally

## Operation
- States: IDLE, RUN, DONE. All outputs registered.
- Reset (rst low): state=IDLE, q=0, loop_idx=0, busy=0, wrap=0, done=0, latched term/loops=0.
- IDLE: start=1 latches term_cnt→term_r, num_loops→loops_r.
  - loops_r != 0 → RUN with q=0, loop_idx=0.
  - num_loops == 0 → DONE directly, no counting.
  - start=0 → remain IDLE.
- RUN, per edge, in priority order:
  - abort=1 → IDLE; q=0, loop_idx=0; no done, no wrap.
  - hold=1 → q, loop_idx unchanged; wrap=0.
  - q != term_r → q=q+1.
  - q == term_r and loop_idx != loops_r-1 → q=0, loop_idx+1, wrap=1.
  - q == term_r and loop_idx == loops_r-1 → q=0, loop_idx=0, wrap=1, done=1, state=DONE.
- DONE: lasts exactly one cycle, then IDLE. abort in DONE → IDLE (same result). start in DONE is ignored.
- start while busy is ignored; inputs not re-latched.
- term_cnt/num_loops changes during a run have no effect.
- term_r = 0: every unstalled RUN cycle is a wrap; q stays 0.
- term_r = 2^WIDTH-1: q covers the full range; wrap occurs via the compare, never via overflow.
- Arithmetic: q and loop_idx are unsigned. q+1 never exceeds term_r. loop_idx never exceeds loops_r-1.

## Timing
- Start latency: start sampled at edge E0 → busy=1 after E0; the first increment appears after E1.
- Unstalled run: done asserts after edge E0 + num_loops×(term_cnt+1); each held cycle adds one cycle.
- wrap and done on the final pass are asserted in the same cycle.
- busy falls one cycle after done; done is never asserted with busy=0.
- Earliest restart: start sampled in the first IDLE cycle after DONE.
- num_loops=0: done (and busy) asserted for one cycle immediately after E0; wrap stays 0.
- Async reset mid-run: outputs return to reset values without waiting for a clock edge; no done is generated.

## Test plan
- Reset: drive rst low mid-run with q=2 → q=0, busy=0, state IDLE before the next edge; after release, idle until start.
- Basic run, term_cnt=3, num_loops=2: q goes 1,2,3,0,1,2,3,0 on E1..E8; wrap is high after E4 and E8; loop_idx is 1 after E4; done=1 after E8; busy=0 after E9.
- Hold: same as the basic run with hold high for 3 cycles during pass 0 at q=2 → q frozen, done delayed to after E11.
- Abort at q=1 in pass 1 → IDLE next edge, q=0, done never asserted; a fresh start then runs normally.
- Corners:
  - term_cnt=0, num_loops=3 → wrap high after E1, E2, E3; done after E3.
  - num_loops=0 → done after E0 only.
  - term_cnt=7, num_loops=1 → q reaches 7, then wraps to 0 with done after E8.
- Ignored inputs:
  - start pulsed during RUN and in the DONE cycle → no relatch, no restart.
  - term_cnt/num_loops changed mid-run → original timing preserved.
